// File: rtl/apple_spawn_ctrl_pkg.sv
// Shared constants, state encoding and cell/pixel helpers for the apple spawner.
// Optional feature macro: APPLE_LINEAR_SCAN_EN (row-major scan fallback and board-full detection).
package apple_spawn_ctrl_pkg;

   localparam int CELL   = 10;
   localparam int GRID_W = 64;
   localparam int GRID_H = 48;

   localparam int CX_W = 6;
   localparam int CY_W = 6;
   localparam int PX_W = 10;
   localparam int PY_W = 9;

   localparam logic [3:0]      MAX_TRIES  = 4'd8;
   localparam logic [CX_W-1:0] LAST_COL   = 6'd63;
   localparam logic [CY_W-1:0] LAST_ROW   = 6'd47;
   localparam logic [11:0]     SCAN_CELLS = 12'd3072;
   localparam logic [PX_W-1:0] CENTRE_X   = 10'd320;
   localparam logic [PY_W-1:0] CENTRE_Y   = 9'd240;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAW   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_SCAN   = 3'd4,
      ST_FULL   = 3'd5
   } state_e;

   // Six random bits cover 0..63; rows 48..63 fold back onto 0..15.
   function automatic logic [CY_W-1:0] fold_row(input logic [CY_W-1:0] ry);
      return (ry >= 6'd48) ? (ry - 6'd48) : ry;
   endfunction

   // x * 10 as x*8 + x*2, no multiplier needed.
   function automatic logic [PX_W-1:0] scale_x(input logic [CX_W-1:0] c);
      return ({4'd0, c} << 3) + ({4'd0, c} << 1);
   endfunction

   function automatic logic [PY_W-1:0] scale_y(input logic [CY_W-1:0] c);
      return ({3'd0, c} << 3) + ({3'd0, c} << 1);
   endfunction

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// Occupancy query handshake between the apple spawner (master) and the snake body tracker (slave).
interface apple_spawn_ctrl_if;
   logic       occ_req;
   logic [5:0] occ_cx;
   logic [5:0] occ_cy;
   logic       occ_ack;
   logic       occ_hit;

   modport master (output occ_req, output occ_cx, output occ_cy,
                   input  occ_ack, input  occ_hit);
   modport slave  (input  occ_req, input  occ_cx, input  occ_cy,
                   output occ_ack, output occ_hit);
endinterface

// File: rtl/apple_cell_map.sv
// Combinational mapping: random word -> candidate grid cell, and grid cell -> pixel position.
module apple_cell_map
   import apple_spawn_ctrl_pkg::*;
(
   input  logic [11:0]     rnd_i,
   input  logic [CX_W-1:0] cx_i,
   input  logic [CY_W-1:0] cy_i,
   output logic [CX_W-1:0] draw_cx_o,
   output logic [CY_W-1:0] draw_cy_o,
   output logic [PX_W-1:0] pix_x_o,
   output logic [PY_W-1:0] pix_y_o
);

   assign draw_cx_o = rnd_i[5:0];
   assign draw_cy_o = fold_row(rnd_i[11:6]);
   assign pix_x_o   = scale_x(cx_i);
   assign pix_y_o   = scale_y(cy_i);

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: draws random cells, queries occupancy, commits a free cell.
// Optional feature macro: APPLE_LINEAR_SCAN_EN -- after MAX_TRIES hits, scan the grid
// row-major and raise board_full when every cell is occupied. Without it, draws retry forever.
module apple_spawn_ctrl
   import apple_spawn_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [15:0]              rnd,
   input  logic                     start_evt,
   input  logic                     eat_evt,
   apple_spawn_ctrl_if.master       occ,
   output logic [PX_W-1:0]          apple_x,
   output logic [PY_W-1:0]          apple_y,
   output logic                     apple_valid,
   output logic                     spawn_done,
   output logic                     board_full
);

   state_e          state_q;
   logic [CX_W-1:0] cx_q;
   logic [CY_W-1:0] cy_q;
   logic [3:0]      tries_q;
   logic            occ_req_q;
   logic [PX_W-1:0] apple_x_q;
   logic [PY_W-1:0] apple_y_q;
   logic            apple_valid_q;
   logic            spawn_done_q;

   logic [CX_W-1:0] draw_cx_s;
   logic [CY_W-1:0] draw_cy_s;
   logic [PX_W-1:0] pix_x_s;
   logic [PY_W-1:0] pix_y_s;
   logic            unused_rnd_s;

`ifdef APPLE_LINEAR_SCAN_EN
   logic            scan_q;
   logic [11:0]     scan_cnt_q;
   logic            board_full_q;
`endif

   // Only 12 random bits are needed for a cell draw.
   assign unused_rnd_s = ^rnd[15:12];

   apple_cell_map u_map (
      .rnd_i     (rnd[11:0]),
      .cx_i      (cx_q),
      .cy_i      (cy_q),
      .draw_cx_o (draw_cx_s),
      .draw_cy_o (draw_cy_s),
      .pix_x_o   (pix_x_s),
      .pix_y_o   (pix_y_s)
   );

   // Spawn FSM with all outputs registered; a late start_evt overrides any in-flight state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cx_q          <= 6'd0;
         cy_q          <= 6'd0;
         tries_q       <= 4'd0;
         occ_req_q     <= 1'b0;
         apple_x_q     <= CENTRE_X;
         apple_y_q     <= CENTRE_Y;
         apple_valid_q <= 1'b1;
         spawn_done_q  <= 1'b0;
`ifdef APPLE_LINEAR_SCAN_EN
         scan_q        <= 1'b0;
         scan_cnt_q    <= 12'd0;
         board_full_q  <= 1'b0;
`endif
      end else begin
         spawn_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_evt || eat_evt) begin
                  state_q       <= ST_DRAW;
                  apple_valid_q <= 1'b0;
                  tries_q       <= 4'd0;
               end
            end
            ST_DRAW: begin
               cx_q      <= draw_cx_s;
               cy_q      <= draw_cy_s;
               occ_req_q <= 1'b1;
               state_q   <= ST_CHECK;
            end
            ST_CHECK: begin
               if (occ.occ_ack) begin
                  occ_req_q <= 1'b0;
                  if (!occ.occ_hit) begin
                     // Pixel scale of the held candidate is ready now, so commit lands next cycle.
                     apple_x_q     <= pix_x_s;
                     apple_y_q     <= pix_y_s;
                     apple_valid_q <= 1'b1;
                     spawn_done_q  <= 1'b1;
                     state_q       <= ST_COMMIT;
`ifdef APPLE_LINEAR_SCAN_EN
                  end else if (scan_q) begin
                     if (scan_cnt_q == SCAN_CELLS) begin
                        board_full_q  <= 1'b1;
                        apple_valid_q <= 1'b0;
                        state_q       <= ST_FULL;
                     end else begin
                        state_q <= ST_SCAN;
                     end
`endif
                  end else if ((tries_q + 4'd1) < MAX_TRIES) begin
                     tries_q <= tries_q + 4'd1;
                     state_q <= ST_DRAW;
                  end else begin
`ifdef APPLE_LINEAR_SCAN_EN
                     scan_q     <= 1'b1;
                     scan_cnt_q <= 12'd0;
                     state_q    <= ST_SCAN;
`else
                     tries_q <= 4'd0;
                     state_q <= ST_DRAW;
`endif
                  end
               end
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
            end
`ifdef APPLE_LINEAR_SCAN_EN
            ST_SCAN: begin
               // Advance one cell row-major, wrapping the last cell back to (0,0).
               if (cx_q == LAST_COL) begin
                  cx_q <= 6'd0;
                  cy_q <= (cy_q == LAST_ROW) ? 6'd0 : (cy_q + 6'd1);
               end else begin
                  cx_q <= cx_q + 6'd1;
               end
               scan_cnt_q <= scan_cnt_q + 12'd1;
               occ_req_q  <= 1'b1;
               state_q    <= ST_CHECK;
            end
            ST_FULL: begin
               state_q <= ST_FULL;
            end
`endif
            default: begin
               state_q   <= ST_IDLE;
               occ_req_q <= 1'b0;
            end
         endcase

         if (start_evt && (state_q != ST_IDLE)) begin
            state_q       <= ST_DRAW;
            tries_q       <= 4'd0;
            occ_req_q     <= 1'b0;
            apple_valid_q <= 1'b0;
            spawn_done_q  <= 1'b0;
`ifdef APPLE_LINEAR_SCAN_EN
            scan_q        <= 1'b0;
            board_full_q  <= 1'b0;
`endif
         end
      end
   end

   assign occ.occ_req = occ_req_q;
   assign occ.occ_cx  = cx_q;
   assign occ.occ_cy  = cy_q;
   assign apple_x     = apple_x_q;
   assign apple_y     = apple_y_q;
   assign apple_valid = apple_valid_q;
   assign spawn_done  = spawn_done_q;
`ifdef APPLE_LINEAR_SCAN_EN
   assign board_full  = board_full_q;
`else
   assign board_full  = 1'b0;
`endif

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Self-checking bench for apple_spawn_ctrl: directed scenarios plus randomized spawns,
// expected cells and pixels computed arithmetically from the random word.
module tb_apple_spawn_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] rnd = 16'd0;
   logic        start_evt = 1'b0;
   logic        eat_evt = 1'b0;
   logic [9:0]  apple_x;
   logic [8:0]  apple_y;
   logic        apple_valid;
   logic        spawn_done;
   logic        board_full;

   int checks = 0;
   int errors = 0;

   apple_spawn_ctrl_if occ ();

   apple_spawn_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rnd         (rnd),
      .start_evt   (start_evt),
      .eat_evt     (eat_evt),
      .occ         (occ.master),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_valid (apple_valid),
      .spawn_done  (spawn_done),
      .board_full  (board_full)
   );

   always #5 clk = ~clk;

   // Reference: column = low six bits, row = next six bits folded modulo the 48 rows.
   function automatic int m_cx(input logic [15:0] r);
      return int'(r) % 64;
   endfunction

   function automatic int m_cy(input logic [15:0] r);
      int ry;
      ry = (int'(r) / 64) % 64;
      return (ry >= 48) ? (ry - 48) : ry;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"},   32'(occ.occ_req), 32'd0);
      chk({tag, "_x"},     32'(apple_x),     32'd320);
      chk({tag, "_y"},     32'(apple_y),     32'd240);
      chk({tag, "_valid"}, 32'(apple_valid), 32'd1);
      chk({tag, "_done"},  32'(spawn_done),  32'd0);
      chk({tag, "_full"},  32'(board_full),  32'd0);
   endtask

   // One full spawn: n_hits occupied draws then a free one; ack held off by delay cycles.
   task automatic spawn(input int n_hits, input int delay, input bit s, input bit e,
                        input bit mid_eat, input logic [15:0] r0);
      logic [15:0] r;
      int ecx;
      int ecy;
      r = r0;
      ecx = 0;
      ecy = 0;
      rnd = r;
      start_evt = s;
      eat_evt = e;
      tick();
      start_evt = 1'b0;
      eat_evt = 1'b0;
      for (int q = 0; q <= n_hits; q++) begin
         chk("draw_req_low", 32'(occ.occ_req), 32'd0);
         tick();
         ecx = m_cx(r);
         ecy = m_cy(r);
         chk("req_high", 32'(occ.occ_req), 32'd1);
         chk("occ_cx", 32'(occ.occ_cx), 32'(ecx));
         chk("occ_cy", 32'(occ.occ_cy), 32'(ecy));
         chk("valid_low", 32'(apple_valid), 32'd0);
         for (int d = 0; d < delay; d++) begin
            if (mid_eat && d == 0) eat_evt = 1'b1;
            tick();
            eat_evt = 1'b0;
            chk("req_hold", 32'(occ.occ_req), 32'd1);
            chk("cx_hold", 32'(occ.occ_cx), 32'(ecx));
            chk("cy_hold", 32'(occ.occ_cy), 32'(ecy));
         end
         occ.occ_ack = 1'b1;
         occ.occ_hit = (q < n_hits);
         if (q < n_hits) begin
            r = 16'($urandom);
            rnd = r;
         end
         tick();
         occ.occ_ack = 1'b0;
         occ.occ_hit = 1'b0;
      end
      chk("commit_done", 32'(spawn_done), 32'd1);
      chk("commit_x", 32'(apple_x), 32'(ecx * 10));
      chk("commit_y", 32'(apple_y), 32'(ecy * 10));
      chk("commit_valid", 32'(apple_valid), 32'd1);
      chk("commit_req", 32'(occ.occ_req), 32'd0);
      tick();
      chk("done_pulse", 32'(spawn_done), 32'd0);
      chk("hold_valid", 32'(apple_valid), 32'd1);
      chk("hold_x", 32'(apple_x), 32'(ecx * 10));
      chk("idle_req", 32'(occ.occ_req), 32'd0);
   endtask

   initial begin
      occ.occ_ack = 1'b0;
      occ.occ_hit = 1'b0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;

      // Reset state held while no events arrive.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_reset_vals("reset_idle");
      end

      // Directed: eat with known word, ack+miss in the first request cycle.
      spawn(0, 0, 1'b0, 1'b1, 1'b0, 16'h0C85);

      // Delayed acknowledge: request and cell stable for 5 cycles.
      spawn(0, 5, 1'b0, 1'b1, 1'b0, 16'($urandom));

      // Three hits then a miss, with an eat pulse during the check that must be ignored.
      spawn(3, 2, 1'b0, 1'b1, 1'b1, 16'($urandom));

      // Start and eat together: exactly one spawn, then quiet.
      spawn(0, 1, 1'b1, 1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("single_spawn_done", 32'(spawn_done), 32'd0);
         chk("single_spawn_req", 32'(occ.occ_req), 32'd0);
      end

      // Randomized spawns.
      for (int i = 0; i < 8; i++) begin
         spawn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
      end

`ifndef APPLE_LINEAR_SCAN_EN
      // Without the scan fallback, draws keep going past MAX_TRIES.
      spawn(10, 0, 1'b0, 1'b1, 1'b0, 16'($urandom));
      chk("no_scan_full", 32'(board_full), 32'd0);
`else
      // Scan fallback: eight draws of (63,47), then a full row-major sweep from (0,0).
      rnd = 16'h0BFF;
      eat_evt = 1'b1;
      tick();
      eat_evt = 1'b0;
      for (int q = 0; q < 8; q++) begin
         chk("sd_req_low", 32'(occ.occ_req), 32'd0);
         tick();
         chk("sd_cell", {20'd0, occ.occ_cx, occ.occ_cy}, {20'd0, 6'd63, 6'd47});
         occ.occ_ack = 1'b1;
         occ.occ_hit = 1'b1;
         tick();
         occ.occ_ack = 1'b0;
      end
      for (int k = 0; k < 3072; k++) begin
         chk("scan_req_low", 32'(occ.occ_req), 32'd0);
         tick();
         chk("scan_cell", {20'd0, occ.occ_cx, occ.occ_cy}, 32'(((k % 64) << 6) | (k / 64)));
         occ.occ_ack = 1'b1;
         occ.occ_hit = 1'b1;
         tick();
         occ.occ_ack = 1'b0;
      end
      occ.occ_hit = 1'b0;
      chk("full_flag", 32'(board_full), 32'd1);
      chk("full_valid", 32'(apple_valid), 32'd0);
      chk("full_req", 32'(occ.occ_req), 32'd0);
      tick();
      chk("full_stay", 32'(board_full), 32'd1);
      chk("full_stay_req", 32'(occ.occ_req), 32'd0);
      spawn(0, 0, 1'b1, 1'b0, 1'b0, 16'h0C85);
      chk("full_cleared", 32'(board_full), 32'd0);
`endif

      // Reset while a query is outstanding aborts in one cycle.
      rnd = 16'($urandom);
      eat_evt = 1'b1;
      tick();
      eat_evt = 1'b0;
      tick();
      chk("pre_reset_req", 32'(occ.occ_req), 32'd1);
      reset_n = 1'b0;
      tick();
      check_reset_vals("mid_reset");
      reset_n = 1'b1;
      tick();
      check_reset_vals("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
